tbl_loader: RTL and testbench

- Front-end stage directly upstream of the math seed/lookup table (256 x 68-bit RAM, write address taken from B[53:46]).
- Streams table contents in from a config/microcode source with auto-incrementing index. Arbitrates the shared table port between loading and lookups.
- Registers lookup results, returning them with a valid strobe one cycle after issue.
- Lookups are blocked while a load is in progress.

---
 rtl/tbl_loader.sv | 108 ++++++++++
 tb/tb_tbl_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tbl_loader.sv
// tbl_loader: streams entries into the 256x68 seed table and arbitrates its port with 1-cycle lookups.
//   Ports: clk/rst (sync, active-high); ld_start/ld_base/ld_count begin a load;
//   ld_valid/ld_data/ld_ready carry load beats; ld_busy/ld_done/ld_err report status;
//   lk_valid/lk_A/lk_xtra/lk_ready issue lookups; rs_valid/rs_data return them one cycle later;
//   tbl_A/tbl_B/tbl_xtra/tbl_is_read/tbl_is_write/tbl_res drive the shared table port.
//   Optional macro TBL_LOAD_CKSUM_EN adds ld_cksum (16-bit running fold of loaded words).
module tbl_loader #(
  parameter int DW = 68,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_start,
  input  logic [IW-1:0] ld_base,
  input  logic [IW:0]   ld_count,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          ld_busy,
  output logic          ld_done,
  output logic          ld_err,
  input  logic          lk_valid,
  input  logic [DW-1:0] lk_A,
  input  logic [1:0]    lk_xtra,
  output logic          lk_ready,
  output logic          rs_valid,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] tbl_A,
  output logic [DW-1:0] tbl_B,
  output logic [1:0]    tbl_xtra,
  output logic          tbl_is_read,
  output logic          tbl_is_write,
`ifdef TBL_LOAD_CKSUM_EN
  output logic [15:0]   ld_cksum,
`endif
  input  logic [DW-1:0] tbl_res
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t        r_state, w_next;
  logic [IW-1:0] r_idx;
  logic [IW:0]   r_rem;
  logic          r_err;
  logic          w_cnt_ok, w_go, w_rd, w_wr;
  // legal count is 1..2**IW: nonzero, and if the top bit is set nothing else may be
  assign w_cnt_ok = (ld_count != '0) && !(ld_count[IW] && |ld_count[IW-1:0]);
  assign w_go     = (r_state == IDLE) && ld_start && w_cnt_ok;
  always_comb begin
    w_next       = r_state;
    ld_ready     = 1'b0;
    lk_ready     = 1'b0;
    ld_busy      = r_state != IDLE;
    ld_done      = r_state == DONE;
    w_rd         = 1'b0;
    w_wr         = 1'b0;
    tbl_A        = '0;
    tbl_B        = '0;
    tbl_xtra     = '0;
    if (r_state == IDLE) begin
      lk_ready = 1'b1;
      w_rd     = lk_valid;
      w_next   = w_go ? LOAD : IDLE;
    end else if (r_state == LOAD) begin
      ld_ready = 1'b1;
      w_wr     = ld_valid;
      w_next   = (ld_valid && r_rem == 1) ? DONE : LOAD;
    end else begin
      w_next = IDLE;
    end
    tbl_A        = w_wr ? ld_data : w_rd ? lk_A : '0;
    tbl_B        = w_wr ? DW'(r_idx) << 46 : '0;
    tbl_xtra     = w_rd ? lk_xtra : 2'b0;
    tbl_is_read  = w_rd;
    tbl_is_write = w_wr;
  end
  assign ld_err = r_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_rem    <= '0;
      r_err    <= 1'b0;
      rs_valid <= 1'b0;
      rs_data  <= '0;
    end else begin
      r_state  <= w_next;
      r_err    <= (r_state == IDLE) && ld_start && !w_cnt_ok;
      rs_valid <= w_rd;
      if (w_rd) rs_data <= tbl_res;
      if (w_go) begin
        r_idx <= ld_base;
        r_rem <= ld_count;
      end else if (w_wr) begin
        r_idx <= r_idx + 1'b1;
        r_rem <= r_rem - 1'b1;
      end
    end
  end
`ifdef TBL_LOAD_CKSUM_EN
  logic [15:0] r_cksum;
  always_ff @(posedge clk) begin
    if (rst) r_cksum <= '0;
    else if (w_go) r_cksum <= '0;
    else if (w_wr) r_cksum <= {r_cksum[14:0], r_cksum[15]} ^ ld_data[15:0] ^ ld_data[31:16]
                              ^ ld_data[47:32] ^ ld_data[63:48] ^ {12'b0, ld_data[67:64]};
  end
  assign ld_cksum = r_cksum;
`endif
endmodule

// File: tb/tb_tbl_loader.sv
// tb_tbl_loader: randomized self-checking bench for tbl_loader against a table/loader reference model.
module tb_tbl_loader;
  logic        clk = 0, rst = 1;
  logic        ld_start = 0, ld_valid = 0, lk_valid = 0;
  logic [7:0]  ld_base = 0;
  logic [8:0]  ld_count = 0;
  logic [67:0] ld_data = 0, lk_A = 0;
  logic [1:0]  lk_xtra = 0;
  logic        ld_ready, ld_busy, ld_done, ld_err, lk_ready, rs_valid, tbl_is_read, tbl_is_write;
  logic [67:0] rs_data, tbl_A, tbl_B, tbl_res;
  logic [1:0]  tbl_xtra;
`ifdef TBL_LOAD_CKSUM_EN
  logic [15:0] ld_cksum;
`endif
  int checks = 0, failures = 0;
  logic        pend = 0;
  logic [67:0] exp_rs = 0;
  logic [67:0] ram [256];
  logic [67:0] exp_mem [256];
  logic [15:0] last_ck = 0;

  always #5 clk = ~clk;

  tbl_loader dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .ld_busy(ld_busy),
    .ld_done(ld_done), .ld_err(ld_err), .lk_valid(lk_valid), .lk_A(lk_A), .lk_xtra(lk_xtra),
    .lk_ready(lk_ready), .rs_valid(rs_valid), .rs_data(rs_data), .tbl_A(tbl_A), .tbl_B(tbl_B),
    .tbl_xtra(tbl_xtra), .tbl_is_read(tbl_is_read), .tbl_is_write(tbl_is_write),
`ifdef TBL_LOAD_CKSUM_EN
    .ld_cksum(ld_cksum),
`endif
    .tbl_res(tbl_res)
  );

  // table environment: write port indexed by B[53:46], read returns entry A[7:0] mixed with xtra
  always @(posedge clk) if (tbl_is_write) ram[tbl_B[53:46]] <= tbl_A;
  assign tbl_res = tbl_is_read ? (ram[tbl_A[7:0]] ^ {66'b0, tbl_xtra}) : '0;

  task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [67:0] rand68();
    return {4'($urandom), $urandom, $urandom};
  endfunction

  function automatic logic [15:0] ck_step(input logic [15:0] c, input logic [67:0] d);
    return {c[14:0], c[15]} ^ d[15:0] ^ d[31:16] ^ d[47:32] ^ d[63:48] ^ {12'b0, d[67:64]};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("rs_valid", rs_valid, pend);
    if (pend) chk("rs_data", rs_data, exp_rs);
    pend = 0;
  endtask

  task automatic drive_lk(input int lk);
    lk_valid = lk == 2 ? 1'b1 : lk == 1 ? 1'($urandom) : 1'b0;
    lk_A     = rand68();
    lk_xtra  = 2'($urandom);
  endtask

  task automatic issue();
    chk("rd_A", tbl_A, lk_A);
    chk("rd_B", tbl_B, 0);
    chk("rd_xtra", tbl_xtra, lk_xtra);
    pend   = 1;
    exp_rs = exp_mem[lk_A[7:0]] ^ {66'b0, lk_xtra};
  endtask

  task automatic idle_cycle(input int lk);
    drive_lk(lk);
    #1;
    chk("idle_lk_ready", lk_ready, 1);
    chk("idle_rd", tbl_is_read, lk_valid);
    chk("idle_wr", tbl_is_write, 0);
    chk("idle_busy", ld_busy, 0);
    if (lk_valid) issue();
    else begin
      chk("idle_A0", tbl_A, 0);
      chk("idle_B0", tbl_B, 0);
      chk("idle_x0", tbl_xtra, 0);
    end
    tick();
    lk_valid = 0;
  endtask

  // gap: 0 none, 1 alternating, 2 random; lk: 0 off, 1 random, 2 held; dmode: 0 random, 1 k+1, 2 cksum vector
  task automatic load(input logic [7:0] base, input int cnt, input int gap, input int lk,
                      input int dmode, input int abort_at);
    logic [7:0]  idx;
    logic [15:0] ck;
    int k, cyc;
    idx = base; ck = 0; k = 0; cyc = 0;
    ld_start = 1; ld_base = base; ld_count = 9'(cnt);
    idle_cycle(lk);
    ld_start = 0;
    if (cnt < 1 || cnt > 256) begin
      chk("err_pulse", ld_err, 1);
      chk("err_idle", ld_busy, 0);
      chk("err_nowr", tbl_is_write, 0);
      tick();
      chk("err_once", ld_err, 0);
      chk("err_idle2", ld_busy, 0);
      return;
    end
    chk("err_none", ld_err, 0);
    while (k < cnt) begin
      ld_valid = gap == 0 ? 1'b1 : gap == 1 ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      ld_data  = dmode == 1 ? 68'(k + 1) : dmode == 2 ? (k == 0 ? 68'h1 : 68'h1_0000_0000_0000_0000) : rand68();
      ld_start = 1'($urandom);
      ld_count = 9'($urandom);
      drive_lk(lk);
      if (k == abort_at) begin
        ld_valid = 0; rst = 1;
        tick();
        rst = 0; ld_start = 0; lk_valid = 0;
        chk("abort_busy", ld_busy, 0);
        chk("abort_done", ld_done, 0);
        tick();
        chk("abort_done2", ld_done, 0);
        chk("abort_busy2", ld_busy, 0);
        return;
      end
      #1;
      chk("ld_ready", ld_ready, 1);
      chk("ld_busy", ld_busy, 1);
      chk("ld_lk_ready", lk_ready, 0);
      chk("ld_no_rd", tbl_is_read, 0);
      chk("ld_wr", tbl_is_write, ld_valid);
      chk("ld_done_low", ld_done, 0);
      if (ld_valid) begin
        chk("wr_idx", tbl_B, {14'b0, idx, 46'b0});
        chk("wr_data", tbl_A, ld_data);
        exp_mem[idx] = ld_data;
        ck = ck_step(ck, ld_data);
        idx++;
        k++;
      end
      cyc++;
      tick();
    end
    ld_valid = 0; ld_start = 1; ld_count = 9'd1;
    drive_lk(lk);
    #1;
    chk("done_pulse", ld_done, 1);
    chk("done_busy", ld_busy, 1);
    chk("done_ld_ready", ld_ready, 0);
    chk("done_lk_ready", lk_ready, 0);
    chk("done_no_rd", tbl_is_read, 0);
    chk("done_no_wr", tbl_is_write, 0);
`ifdef TBL_LOAD_CKSUM_EN
    chk("cksum", ld_cksum, ck);
`endif
    last_ck = ck;
    tick();
    ld_start = 0;
    chk("done_once", ld_done, 0);
    chk("idle_after", ld_busy, 0);
    idle_cycle(lk == 2 ? 2 : 0);
`ifdef TBL_LOAD_CKSUM_EN
    chk("cksum_hold", ld_cksum, ck);
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin ram[i] = 0; exp_mem[i] = 0; end
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ld_ready", ld_ready, 0);
      chk("rst_busy", ld_busy, 0);
      chk("rst_done", ld_done, 0);
      chk("rst_err", ld_err, 0);
      chk("rst_rs_data", rs_data, 0);
      chk("rst_lk_ready", lk_ready, 1);
      chk("rst_tbl", {tbl_is_read, tbl_is_write, tbl_xtra} , 0);
    end
    load(8'hFE, 4, 0, 0, 1, -1);
    load(8'h10, 3, 1, 2, 0, -1);
    load(8'h20, 0, 0, 0, 0, -1);
    load(8'h20, 257, 0, 0, 0, -1);
    load(8'h40, 5, 0, 1, 0, 2);
    load(8'h00, 1, 0, 0, 0, -1);
    load(8'h30, 2, 0, 0, 2, -1);
`ifdef TBL_LOAD_CKSUM_EN
    chk("cksum_vec", ld_cksum, 16'h0003);
`endif
    load(8'h80, 256, 2, 1, 0, -1);
    for (int r = 0; r < 25; r++) begin
      int n = $urandom_range(0, 9);
      int c = n == 0 ? 0 : n == 1 ? $urandom_range(257, 511) : $urandom_range(1, 20);
      for (int j = 0; j < int'($urandom_range(1, 6)); j++) idle_cycle(1);
      load(8'($urandom), c, 2, 1, 0, $urandom_range(0, 7) == 0 ? $urandom_range(0, 3) : -1);
    end
    for (int j = 0; j < 200; j++) idle_cycle(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
